slice_sequencer: RTL

- Upstream/downstream wrapper for the 25-bit slice datapath.
- Accepts a full 64-slice state over a valid/ready input stream and buffers it in a 64x25 RAM.
- Issues each slice to the datapath on `line` with a one-cycle `set` strobe, then waits for `calc`.
- Writes each `mem` result back in place, and when all 64 are done, streams the results out over a valid/ready output.

---
 rtl/slice_pkg.sv | 18 +
 rtl/slice_ram.sv | 27 ++
 rtl/slice_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/slice_pkg.sv
// Shared constants and state encoding for the slice sequencer and its buffer RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package slice_pkg;

  localparam int SLICE_W = 25;   // bits per slice
  localparam int DEPTH   = 64;   // slices per frame
  localparam int ADDR_W  = 6;    // log2(DEPTH)
  localparam int TIMEOUT = 255;  // WAIT cycles without a calc edge before re-issue

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/slice_ram.sv
// Frame buffer: DEPTH x SLICE_W, one synchronous write port, one asynchronous read port.
// Latency: write visible to the read port the cycle after we; read is combinational.
// Backpressure: none, accepts a write every cycle.
// Ports: clk; we/waddr/wdata write port; raddr -> rdata read port.
// Contents are intentionally not reset; every frame overwrites all entries before use.
module slice_ram
  import slice_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [SLICE_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [SLICE_W-1:0] rdata
);

  logic [SLICE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/slice_sequencer.sv
// Buffers a 64-slice frame, issues each slice to the datapath (set strobe, wait for a calc edge), writes results back, streams them out.
// Latency: 64 input cycles, >=2 cycles per slice processed, first out_valid 1 cycle after the last calc edge.
// Backpressure: in_ready only in LOAD; out_valid holds data stable until out_ready; stalled slices retry after TIMEOUT.
// Ports: in_valid/in_ready/in_slice upstream stream; line/set/calc/mem datapath interface;
//        out_valid/out_ready/out_slice/out_last downstream stream; busy (not in LOAD); err (sticky timeout flag).
module slice_sequencer
  import slice_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SLICE_W-1:0] in_slice,
  output logic [SLICE_W-1:0] line,
  output logic               set,
  input  logic               calc,
  input  logic [SLICE_W-1:0] mem,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SLICE_W-1:0] out_slice,
  output logic               out_last,
  output logic               busy,
  output logic               err
);

  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [7:0]        TO_MAX = 8'(TIMEOUT);

  state_e             state, state_nxt;
  logic [ADDR_W-1:0]  wr_ptr, wr_ptr_nxt;
  logic [ADDR_W-1:0]  idx, idx_nxt, idx_inc;
  logic [7:0]         wait_cnt, wait_cnt_nxt;
  logic               calc_q, calc_rise;
  logic [SLICE_W-1:0] line_nxt, out_slice_nxt;
  logic               set_nxt, out_valid_nxt, out_last_nxt, err_nxt;
  logic               in_hs, out_hs;

  logic               ram_we;
  logic [ADDR_W-1:0]  ram_waddr, ram_raddr;
  logic [SLICE_W-1:0] ram_wdata, ram_rdata;

  slice_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign in_ready  = (state == LOAD);
  assign busy      = (state != LOAD);
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  // A calc level left high by the previous slice must not complete the next one.
  assign calc_rise = calc & ~calc_q;
  assign idx_inc   = idx + ADDR_W'(1);

  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    idx_nxt       = idx;
    wait_cnt_nxt  = wait_cnt;
    line_nxt      = line;
    set_nxt       = 1'b0;
    out_valid_nxt = out_valid;
    out_slice_nxt = out_slice;
    out_last_nxt  = out_last;
    err_nxt       = err;
    ram_we        = 1'b0;
    ram_waddr     = wr_ptr;
    ram_wdata     = in_slice;
    ram_raddr     = idx;

    case (state)
      LOAD: begin
        if (in_hs) begin
          ram_we     = 1'b1;
          wr_ptr_nxt = wr_ptr + ADDR_W'(1);
          // First slice of a new frame clears the previous frame's timeout flag.
          if (wr_ptr == '0) err_nxt = 1'b0;
          if (wr_ptr == LAST) begin
            idx_nxt   = '0;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        line_nxt     = ram_rdata;
        set_nxt      = 1'b1;
        wait_cnt_nxt = '0;
        state_nxt    = WAIT;
      end
      WAIT: begin
        if (calc_rise) begin
          ram_we    = 1'b1;
          ram_waddr = idx;
          ram_wdata = mem;
          if (idx == LAST) begin
            // Prefetch slice 0 so out_valid rises on the very next cycle.
            ram_raddr     = '0;
            idx_nxt       = '0;
            out_valid_nxt = 1'b1;
            out_slice_nxt = ram_rdata;
            out_last_nxt  = (LAST == '0);
            state_nxt     = DRAIN;
          end else begin
            idx_nxt   = idx_inc;
            state_nxt = ISSUE;
          end
        end else if (wait_cnt == TO_MAX) begin
          err_nxt   = 1'b1;
          state_nxt = ISSUE;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      DRAIN: begin
        if (out_hs) begin
          if (idx == LAST) begin
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
            idx_nxt       = '0;
            state_nxt     = LOAD;
          end else begin
            ram_raddr     = idx_inc;
            idx_nxt       = idx_inc;
            out_slice_nxt = ram_rdata;
            out_last_nxt  = (idx_inc == LAST);
          end
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      wr_ptr    <= '0;
      idx       <= '0;
      wait_cnt  <= '0;
      calc_q    <= 1'b0;
      line      <= '0;
      set       <= 1'b0;
      out_valid <= 1'b0;
      out_slice <= '0;
      out_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      idx       <= idx_nxt;
      wait_cnt  <= wait_cnt_nxt;
      calc_q    <= calc;
      line      <= line_nxt;
      set       <= set_nxt;
      out_valid <= out_valid_nxt;
      out_slice <= out_slice_nxt;
      out_last  <= out_last_nxt;
      err       <= err_nxt;
    end
  end

endmodule
